// File: rtl/fetch_unit_pkg.sv
// Purpose: shared constants and types for the fetch unit and its predecoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_unit_pkg;

  // First fetch address after reset.
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Primary opcode field values (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  // R-type funct field value (instr[5:0]) for jr.
  localparam logic [5:0] FUNCT_JR = 6'h08;

  // Canonical no-op; also the instruction word of an F/D bubble.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_predecode.sv
// Purpose: combinational next-pc predictor from the word currently being fetched.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether npc is consumed.
//
// Ports:
//   pc    - address of the word being fetched
//   idata - instruction word at pc
//   npc   - predicted next fetch address (branches predicted taken,
//           direct jumps followed, jr and everything else fall through)
module fetch_predecode
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] idata,
  output logic [31:0] npc
);

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [5:0]  opcode;

  assign opcode    = idata[31:26];
  assign pc_plus4  = pc + 32'd4;
  // Sign-extended halfword immediate scaled to a word offset.
  assign br_offset = {{14{idata[15]}}, idata[15:0], 2'b00};

  always_comb begin
    npc = pc_plus4;
    case (opcode)
      OP_BEQ, OP_BNE: npc = pc_plus4 + br_offset;
      OP_J, OP_JAL:   npc = {pc_plus4[31:28], idata[25:0], 2'b00};
      default:        npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Purpose: instruction fetch stage with predecode-based next-pc, F/D register and halt/redirect control.
// Latency: 1 cycle iaddr->prev; redirect target on iaddr 1 cycle after miss is taken, on prev 1 cycle later.
// Backpressure: stall freezes pc, F/D, state and counters; miss/halt_req are ignored while stalled.
//
// Ports:
//   clk, reset      - clock and asynchronous active-high reset
//   iaddr / idata   - combinational instruction memory port (iaddr = pc)
//   stall           - decode hold
//   halt_req        - level request to stop fetching
//   miss / rpc      - redirect for the instruction in decode, with target
//   prev, prev_pc, prev_valid - F/D register contents
//   halted          - high while in the halted state
//   fetch_count, redirect_count - free-running wrap-around event counters
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        miss,
  input  logic [31:0] rpc,
  output logic [31:0] prev,
  output logic [31:0] prev_pc,
  output logic        prev_valid,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic [31:0] redirect_count
);

  fetch_state_t state, state_nxt;

  logic [31:0] pc, pc_nxt;
  logic [31:0] npc;
  logic [31:0] prev_nxt, prev_pc_nxt;
  logic        prev_valid_nxt;
  logic [31:0] fetch_count_nxt, redirect_count_nxt;

  fetch_predecode u_predecode (
    .pc    (pc),
    .idata (idata),
    .npc   (npc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    pc_nxt             = pc;
    prev_nxt           = prev;
    prev_pc_nxt        = prev_pc;
    prev_valid_nxt     = prev_valid;
    fetch_count_nxt    = fetch_count;
    redirect_count_nxt = redirect_count;

    if (!stall) begin
      case (state)
        // Single settling cycle after reset; the reset bubble stays in F/D.
        ST_BOOT: begin
          state_nxt = ST_RUN;
        end

        ST_RUN: begin
          if (miss) begin
            state_nxt          = ST_RUN;
            pc_nxt             = rpc;
            prev_nxt           = NOP_WORD;
            prev_pc_nxt        = rpc;
            prev_valid_nxt     = 1'b0;
            redirect_count_nxt = redirect_count + 32'd1;
          end else if (halt_req) begin
            // pc is held so fetch resumes nowhere until a redirect arrives.
            state_nxt      = ST_HALTED;
            prev_nxt       = NOP_WORD;
            prev_pc_nxt    = pc;
            prev_valid_nxt = 1'b0;
          end else begin
            pc_nxt          = npc;
            prev_nxt        = idata;
            prev_pc_nxt     = pc;
            prev_valid_nxt  = 1'b1;
            fetch_count_nxt = fetch_count + 32'd1;
          end
        end

        ST_HALTED: begin
          // Only a redirect leaves HALTED; F/D already holds a bubble.
          if (miss) begin
            state_nxt          = ST_RUN;
            pc_nxt             = rpc;
            prev_nxt           = NOP_WORD;
            prev_pc_nxt        = rpc;
            prev_valid_nxt     = 1'b0;
            redirect_count_nxt = redirect_count + 32'd1;
          end
        end

        default: begin
          state_nxt = ST_BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc             <= RESET_PC;
      prev           <= 32'h0;
      prev_pc        <= 32'h0;
      prev_valid     <= 1'b0;
      fetch_count    <= 32'h0;
      redirect_count <= 32'h0;
    end else begin
      pc             <= pc_nxt;
      prev           <= prev_nxt;
      prev_pc        <= prev_pc_nxt;
      prev_valid     <= prev_valid_nxt;
      fetch_count    <= fetch_count_nxt;
      redirect_count <= redirect_count_nxt;
    end
  end

  assign iaddr  = pc;
  assign halted = (state == ST_HALTED);

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 iaddr  output  32  instruction-memory address (= current pc); memory is combinational.
REQ-005 idata  input  32  instruction word at iaddr, same cycle.
REQ-006 stall  input  1  decode hold; fetch state and F/D register freeze.
REQ-007 halt_req  input  1  level request to stop fetching.
REQ-008 miss  input  1  redirect from branch resolver for the instruction currently in decode.
REQ-009 rpc  input  32  redirect target, valid when miss=1.
REQ-010 prev  output  32  F/D instruction register (decode-stage instruction).
REQ-011 prev_pc  output  32  address of prev.
REQ-012 prev_valid  output  1  prev holds a real fetched instruction.
REQ-013 halted  output  1  high in HALTED state.
REQ-014 fetch_count  output  32  instructions accepted into F/D.
REQ-015 redirect_count  output  32  redirects acted upon.

Function
REQ-016 States: BOOT, RUN, HALTED; BOOT lasts exactly one cycle after reset release, then RUN; no fetch into F/D in BOOT.
REQ-017 Predecode of idata selects predicted next pc (npc): beq/bne -> pc+4+(sext(imm16)<<2) (predict taken); j/jal -> {pc+4[31:28], idx26, 2'b00}; jr and all others -> pc+4.
REQ-018 All pc arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-019 RUN, stall=0, miss=0, halt_req=0: F/D <= {idata, pc, valid=1}; pc <= npc; fetch_count += 1.
REQ-020 stall=1 (any state): pc, F/D, state, counters hold; miss and halt_req ignored that cycle.
REQ-021 RUN or HALTED, stall=0, miss=1: pc <= rpc; F/D <= {32'h0, rpc, valid=0} bubble; redirect_count += 1; state <= RUN.
REQ-022 miss has priority over halt_req when both asserted with stall=0.
REQ-023 RUN, stall=0, miss=0, halt_req=1: F/D <= bubble; pc holds; state <= HALTED.
REQ-024 HALTED: pc holds, F/D bubble, no counting; exit only via REQ-021 or reset; halt_req ignored.
REQ-025 Redirect-to-fetch latency: fetch at rpc is presented on iaddr the cycle after miss is acted upon; the instruction at rpc appears on prev one cycle later.
REQ-026 Counters wrap at 2^32 without saturation.
REQ-027 iaddr equals pc in every state including BOOT and HALTED.

Reset
REQ-028 On reset: pc=RESET_PC, state=BOOT, prev=0, prev_pc=0, prev_valid=0, halted=0, both counters=0.
REQ-029 Reset asserted mid-operation overrides stall, miss, halt_req and takes effect immediately (asynchronous).

Structure
REQ-030 Shared package holds opcode/funct constants (RTYPE, BEQ, BNE, J, JAL, JR funct), NOP word, and the state enum.
REQ-031 Next-pc predecode is one combinational sub-module, fetch_predecode (inputs pc, idata; output npc).
REQ-032 Total state: pc, F/D register, state, two counters; no other storage.

Verification
REQ-033 Reset release, idata=NOP always -> BOOT one cycle with prev_valid=0, then prev_pc 0,4,8 on successive cycles, fetch_count=3 after third.
REQ-034 pc=0x100, idata beq imm=16'hFFFE -> next iaddr=0x0FC; imm=0x0003 -> next iaddr=0x110.
REQ-035 pc=0x1000_0000, idata j idx=0x40 -> next iaddr=0x1000_0100.
REQ-036 miss=1, rpc=0x200, stall=0 -> next cycle iaddr=0x200, prev_valid=0, redirect_count+1; with stall=1 same cycle -> no change.
REQ-037 halt_req=1 in RUN -> halted=1, iaddr frozen, fetch_count frozen; later miss=1, rpc=0x40 -> RUN, iaddr=0x40.
REQ-038 pc=32'hFFFF_FFFC, idata=NOP -> next iaddr=0; reset asserted mid-stall -> immediate reset values.
